lives_sprite_reader: RTL and testbench
======================================

LIVES_SPRITE_READER -- requirements
Module: lives_sprite_reader

Interface
REQ-001 Parameter ADDRESS, default 8, is the icon ROM address width (16x16 icon, {row[3:0], col[3:0]}).
REQ-002 Parameter COLOR_BITS, default 24, is the RGB pixel width.
REQ-003 Parameter MAX_LIVES, default 5, is the life counter ceiling.
REQ-004 Parameter START_LIVES, default 3, is the value loaded on reset and restart.
REQ-005 Parameters X0 and Y0, default 16 and 16, give the top-left screen position of icon 0.
REQ-006 Parameter SPACING, default 20, is the horizontal pitch between icons (SPACING >= 16).
REQ-007 Parameter TRANSPARENT, default 24'h000000, is the key colour treated as see-through.
REQ-008 clk  input  1  the single pixel clock; all state is on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 hcount  input  10  current pixel column from the video timing generator.
REQ-011 vcount  input  10  current pixel row from the video timing generator.
REQ-012 video_on  input  1  high in the active display area.
REQ-013 life_lost  input  1  one-cycle pulse: decrement the life count.
REQ-014 life_gain  input  1  one-cycle pulse: increment the life count.
REQ-015 game_restart  input  1  one-cycle pulse: reload START_LIVES.
REQ-016 rom_addr  output  ADDRESS  address to the icon ROM (registered).
REQ-017 rom_data  input  COLOR_BITS  icon ROM data, combinationally valid for rom_addr in the same cycle.
REQ-018 pixel_valid  output  1  high when pixel_rgb is an opaque icon pixel.
REQ-019 pixel_rgb  output  COLOR_BITS  icon colour, zero when pixel_valid is low.
REQ-020 lives  output  3  live life count.
REQ-021 game_over  output  1  high while lives == 0.

Function
REQ-022 Counter priority per cycle: game_restart > (life_lost and life_gain both high: no change) > life_lost > life_gain.
REQ-023 life_lost at lives == 0 leaves 0; life_gain at lives == MAX_LIVES leaves MAX_LIVES (saturating, no wrap).
REQ-024 lives and game_over update on the clock edge after the pulse (1-cycle latency).
REQ-025 Shadow register disp_lives copies lives on the edge where hcount == 0 and vcount == 0; rendering uses only disp_lives, so count changes never tear a frame.
REQ-026 Stage 1 (registered): icon i (0 <= i < MAX_LIVES) is hit when Y0 <= vcount < Y0+16, X0+i*SPACING <= hcount < X0+i*SPACING+16 and i < disp_lives; at most one icon hits.
REQ-027 Stage 1 drives rom_addr = {(vcount-Y0)[3:0], (hcount-X0-i*SPACING)[3:0]} on hit and holds its previous value otherwise; it also registers hit_d and video_on_d.
REQ-028 Stage 2 (registered): pixel_valid = hit_d & video_on_d & (rom_data != TRANSPARENT); pixel_rgb = rom_data when pixel_valid, else 0.
REQ-029 Total latency from hcount/vcount to pixel_rgb/pixel_valid is exactly 2 cycles.
REQ-030 Gaps between icons (SPACING-16 columns) and all out-of-window coordinates give pixel_valid = 0.
REQ-031 video_on low forces pixel_valid = 0 two cycles later regardless of hit.
REQ-032 No division or multiplier on the pixel path; icon offsets are compile-time constants.

Reset
REQ-033 rst_n low asynchronously sets lives = START_LIVES, disp_lives = START_LIVES, rom_addr = 0, hit_d = 0, video_on_d = 0, pixel_valid = 0, pixel_rgb = 0, game_over = (START_LIVES == 0).
REQ-034 Reset asserted mid-frame clears the pipeline immediately; the first opaque pixel after release appears no earlier than 2 cycles after a valid hit coordinate.
REQ-035 Pulses coincident with rst_n low are ignored.

Verification
REQ-036 After reset, hcount=16, vcount=16, video_on=1, ROM[0]=24'hFF0000 -> rom_addr=0 after 1 cycle, pixel_rgb=24'hFF0000, pixel_valid=1 after 2 cycles.
REQ-037 Default parameters, disp_lives=3: hcount=56,vcount=20 hits icon 2 with rom_addr=8'h40; hcount=76 (icon 3) and hcount=33 (gap) -> pixel_valid=0.
REQ-038 Four life_lost pulses from 3 -> lives 2,1,0,0, game_over=1 after the third; five life_gain pulses from 0 -> lives saturates at 5.
REQ-039 life_lost and life_gain in the same cycle at lives=3 -> lives stays 3; adding game_restart in that cycle -> lives=3, game_over=0.
REQ-040 life_lost at mid-frame (vcount=100) -> lives=2 next cycle, icon 2 still drawn until hcount=0,vcount=0, then absent in the next frame.
REQ-041 ROM returns TRANSPARENT at a hit coordinate -> pixel_valid=0, pixel_rgb=0; rst_n pulsed low mid-icon -> pixel_valid=0 immediately, lives=3.

Source files
------------

// File: rtl/lives_sprite_reader.sv
`default_nettype none
// ============================================================================
//  Module   : lives_sprite_reader
//  Purpose  : Tracks the player's life count and renders one 16x16 heart icon
//             per remaining life from an external icon ROM. Two-stage pixel
//             pipeline: stage 1 decodes the hit and drives the ROM address,
//             stage 2 applies the transparency key.
//  Revision : 1.0  initial release
// ============================================================================
module lives_sprite_reader #(
  parameter int                    ADDRESS     = 8,
  parameter int                    COLOR_BITS  = 24,
  parameter int                    MAX_LIVES   = 5,
  parameter int                    START_LIVES = 3,
  parameter int                    X0          = 16,
  parameter int                    Y0          = 16,
  parameter int                    SPACING     = 20,
  parameter logic [COLOR_BITS-1:0] TRANSPARENT = 24'h000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  video_on,
  input  logic                  life_lost,
  input  logic                  life_gain,
  input  logic                  game_restart,
  output logic [ADDRESS-1:0]    rom_addr,
  input  logic [COLOR_BITS-1:0] rom_data,
  output logic                  pixel_valid,
  output logic [COLOR_BITS-1:0] pixel_rgb,
  output logic [2:0]            lives,
  output logic                  game_over
);

  localparam logic [2:0]  MAX_L   = 3'(MAX_LIVES);
  localparam logic [2:0]  START_L = 3'(START_LIVES);
  localparam logic [10:0] Y_LO    = 11'(Y0);
  localparam logic [10:0] Y_HI    = 11'(Y0 + 16);

  logic [2:0] lives_next;
  logic [2:0] disp_lives;
  logic       hit_d;
  logic       video_on_d;

  // Next life count: restart wins, simultaneous lose/gain cancel, saturate at both ends
  always_comb begin
    lives_next = lives;
    if (game_restart) begin
      lives_next = START_L;
    end else if (life_lost && life_gain) begin
      lives_next = lives;
    end else if (life_lost) begin
      if (lives != 3'd0) lives_next = lives - 3'd1;
    end else if (life_gain) begin
      if (lives < MAX_L) lives_next = lives + 3'd1;
    end
  end

  // Life counter and game-over flag, one cycle after the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lives     <= START_L;
      game_over <= (START_LIVES == 0);
    end else begin
      lives     <= lives_next;
      game_over <= (lives_next == 3'd0);
    end
  end

  // Frame-start snapshot of the count so a frame is never drawn with two counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_lives <= START_L;
    end else if (hcount == 10'd0 && vcount == 10'd0) begin
      disp_lives <= lives;
    end
  end

  // Icon hit decode: icon offsets are elaboration constants, no arithmetic on hcount
  logic                 v_in;
  logic [3:0]           row;
  logic [MAX_LIVES-1:0] hit_vec;
  logic [3:0]           col_vec [MAX_LIVES];
  logic [3:0]           col;
  logic                 hit;

  assign v_in = ({1'b0, vcount} >= Y_LO) && ({1'b0, vcount} < Y_HI);
  // Low nibble of (vcount - Y0) only depends on the low nibbles
  assign row  = vcount[3:0] - Y_LO[3:0];

  for (genvar i = 0; i < MAX_LIVES; i++) begin : g_icon
    localparam logic [10:0] XS  = 11'(X0 + i * SPACING);
    localparam logic [10:0] XE  = 11'(X0 + i * SPACING + 16);
    localparam logic [2:0]  IDX = 3'(i);
    assign hit_vec[i] = v_in && ({1'b0, hcount} >= XS) && ({1'b0, hcount} < XE)
                        && (IDX < disp_lives);
    assign col_vec[i] = hit_vec[i] ? (hcount[3:0] - XS[3:0]) : 4'd0;
  end

  // Icons never overlap, so OR-merging the masked column offsets selects the hit one
  always_comb begin
    col = 4'd0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      col = col | col_vec[i];
    end
    hit = |hit_vec;
  end

  // Stage 1: ROM address (held when nothing is hit), hit and blanking delayed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      hit_d      <= 1'b0;
      video_on_d <= 1'b0;
    end else begin
      if (hit) rom_addr <= ADDRESS'({row, col});
      hit_d      <= hit;
      video_on_d <= video_on;
    end
  end

  // Stage 2: transparency key and output colour gating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      pixel_rgb   <= '0;
    end else begin
      if (hit_d && video_on_d && (rom_data != TRANSPARENT)) begin
        pixel_valid <= 1'b1;
        pixel_rgb   <= rom_data;
      end else begin
        pixel_valid <= 1'b0;
        pixel_rgb   <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lives_sprite_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lives_sprite_reader
//  Purpose  : Directed self-checking bench for lives_sprite_reader with a
//             small behavioural icon ROM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lives_sprite_reader;

  logic        clk;
  logic        rst_n;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_on;
  logic        life_lost;
  logic        life_gain;
  logic        game_restart;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic        pixel_valid;
  logic [23:0] pixel_rgb;
  logic [2:0]  lives;
  logic        game_over;
  logic        force_transp;

  int checks = 0;
  int errors = 0;

  lives_sprite_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hcount       (hcount),
    .vcount       (vcount),
    .video_on     (video_on),
    .life_lost    (life_lost),
    .life_gain    (life_gain),
    .game_restart (game_restart),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pixel_valid  (pixel_valid),
    .pixel_rgb    (pixel_rgb),
    .lives        (lives),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Icon ROM model: address 0 is red, others encode their address
  always_comb begin
    if (force_transp)        rom_data = 24'h000000;
    else if (rom_addr == 8'h00) rom_data = 24'hFF0000;
    else                     rom_data = {8'h11, rom_addr, 8'h22};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
  endtask

  initial begin
    rst_n = 1'b0; hcount = '0; vcount = '0; video_on = 1'b0;
    life_lost = 1'b0; life_gain = 1'b0; game_restart = 1'b0; force_transp = 1'b0;
    #12;
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_go", 32'(game_over), 32'd0);
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    chk("rst_rgb", 32'(pixel_rgb), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First pixel of icon 0
    pix(16, 16); video_on = 1'b1;
    step();
    chk("lat1_addr", 32'(rom_addr), 32'h00);
    chk("lat1_valid", 32'(pixel_valid), 32'd0);
    step();
    chk("lat2_valid", 32'(pixel_valid), 32'd1);
    chk("lat2_rgb", 32'(pixel_rgb), 32'hFF0000);

    // Icon 2, row 4 col 0
    pix(56, 20);
    step();
    chk("ic2_addr", 32'(rom_addr), 32'h40);
    step();
    chk("ic2_valid", 32'(pixel_valid), 32'd1);
    chk("ic2_rgb", 32'(pixel_rgb), 32'h114022);

    // Last column of icon 1, last row
    pix(51, 31);
    step();
    chk("ic1_edge_addr", 32'(rom_addr), 32'hFF);
    step();
    chk("ic1_edge_rgb", 32'(pixel_rgb), 32'h11FF22);

    // Icon 3 not displayed with 3 lives; rom_addr holds
    pix(76, 20);
    step();
    chk("ic3_addr_hold", 32'(rom_addr), 32'hFF);
    step();
    chk("ic3_valid", 32'(pixel_valid), 32'd0);

    // Gap between icon 0 and icon 1
    pix(33, 20);
    step(); step();
    chk("gap_valid", 32'(pixel_valid), 32'd0);
    chk("gap_rgb", 32'(pixel_rgb), 32'd0);

    // Below the icon row
    pix(20, 32);
    step(); step();
    chk("below_valid", 32'(pixel_valid), 32'd0);

    // Blanking at a hit coordinate
    pix(20, 20); video_on = 1'b0;
    step(); step();
    chk("blank_valid", 32'(pixel_valid), 32'd0);
    video_on = 1'b1;

    // Transparent key colour at a hit coordinate
    force_transp = 1'b1;
    pix(21, 21);
    step(); step();
    chk("transp_valid", 32'(pixel_valid), 32'd0);
    chk("transp_rgb", 32'(pixel_rgb), 32'd0);
    force_transp = 1'b0;

    // Counter: four losses then five gains
    pix(300, 300);
    life_lost = 1'b1;
    step(); chk("lost1", 32'(lives), 32'd2); chk("lost1_go", 32'(game_over), 32'd0);
    step(); chk("lost2", 32'(lives), 32'd1);
    step(); chk("lost3", 32'(lives), 32'd0); chk("lost3_go", 32'(game_over), 32'd1);
    step(); chk("lost4_sat", 32'(lives), 32'd0);
    life_lost = 1'b0; life_gain = 1'b1;
    step(); chk("gain1", 32'(lives), 32'd1); chk("gain1_go", 32'(game_over), 32'd0);
    step(); chk("gain2", 32'(lives), 32'd2);
    step(); chk("gain3", 32'(lives), 32'd3);
    step(); chk("gain4", 32'(lives), 32'd4);
    step(); chk("gain5_sat", 32'(lives), 32'd5);
    step(); chk("gain6_sat", 32'(lives), 32'd5);
    life_gain = 1'b0;

    // Restart from 5, then simultaneous lose/gain
    game_restart = 1'b1;
    step(); chk("restart", 32'(lives), 32'd3);
    game_restart = 1'b0; life_lost = 1'b1; life_gain = 1'b1;
    step(); chk("both_hold", 32'(lives), 32'd3);
    life_gain = 1'b0;
    step(); chk("lost_to2", 32'(lives), 32'd2);
    life_gain = 1'b1; game_restart = 1'b1;
    step(); chk("all3_lives", 32'(lives), 32'd3); chk("all3_go", 32'(game_over), 32'd0);
    life_lost = 1'b0; life_gain = 1'b0; game_restart = 1'b0;

    // Mid-frame loss: icon 2 stays until the next frame start
    pix(0, 0);
    step();
    pix(200, 100); life_lost = 1'b1;
    step(); chk("mid_lives", 32'(lives), 32'd2);
    life_lost = 1'b0;
    pix(56, 20);
    step(); step();
    chk("mid_ic2_kept", 32'(pixel_valid), 32'd1);
    pix(0, 0);
    step();
    pix(56, 20);
    step(); step();
    chk("next_ic2_gone", 32'(pixel_valid), 32'd0);
    pix(36, 20);
    step(); step();
    chk("next_ic1_kept", 32'(pixel_valid), 32'd1);

    // Reset mid-icon with a pulse held during reset
    pix(20, 20);
    step(); step();
    chk("pre_rst_valid", 32'(pixel_valid), 32'd1);
    rst_n = 1'b0; life_lost = 1'b1;
    #1;
    chk("arst_valid", 32'(pixel_valid), 32'd0);
    chk("arst_lives", 32'(lives), 32'd3);
    chk("arst_addr", 32'(rom_addr), 32'd0);
    step();
    chk("rst_pulse_ign", 32'(lives), 32'd3);
    life_lost = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_1cyc", 32'(pixel_valid), 32'd0);
    step();
    chk("post_rst_2cyc", 32'(pixel_valid), 32'd1);
    chk("post_rst_rgb", 32'(pixel_rgb), 32'h114422);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
